// File: rtl/cpu_dbg_pkg.sv
// Shared run-control encodings and default widths for the CPU debug logic.
package cpu_dbg_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10
  } run_state_e;

  typedef enum logic [1:0] {
    HC_NONE       = 2'b00,
    HC_HOST       = 2'b01,
    HC_STEP_DONE  = 2'b10,
    HC_BREAKPOINT = 2'b11
  } halt_cause_e;

  // Instruction fetches are word aligned, so the byte offset never takes part.
  function automatic logic pc_word_eq(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/cpu_bp_match.sv
// Single hardware PC breakpoint: address comparator plus the armed flag that
// lets execution resume past the breakpoint instruction exactly once.
module cpu_bp_match
  import cpu_dbg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc_cur,
  input  logic        bp_clear,
  input  logic        commit,
  output logic        bp_match
);

  logic bp_armed;

  // Disarmed by a breakpoint halt, re-armed by the next committed instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bp_armed <= 1'b1;
    end else if (bp_clear) begin
      bp_armed <= 1'b0;
    end else if (commit) begin
      bp_armed <= 1'b1;
    end
  end

  assign bp_match = bp_en & bp_armed & pc_word_eq(pc_cur, bp_addr);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: halt / run / N-step / breakpoint, producing the
// commit enable for the PC and register file plus a retired-instruction count.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter bit AUTO_RUN = 1'b0,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STEP_W   = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_n,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc_cur,
  output logic              pc_we,
  output logic              halted,
  output logic [1:0]        run_state,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  instr_cnt
);

  run_state_e        state;
  halt_cause_e       cause;
  logic [STEP_W-1:0] step_cnt;
  logic              auto_pend;
  logic              auto_go;
  logic              active;
  logic              commit;
  logic              bp_match;
  logic              bp_clear;

  function automatic logic [STEP_W-1:0] step_load(input logic [STEP_W-1:0] n);
    return (n == '0) ? STEP_W'(1) : n;
  endfunction

  cpu_bp_match u_bp (
    .clk      (clk),
    .rst_n    (rst_n),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .pc_cur   (pc_cur),
    .bp_clear (bp_clear),
    .commit   (commit),
    .bp_match (bp_match)
  );

  assign active   = (state != ST_HALTED);
  // A host halt outranks a breakpoint, so it must not disarm the breakpoint.
  assign commit   = rst_n & active & ~halt_req & ~bp_match;
  assign bp_clear = rst_n & active & ~halt_req & bp_match;
  assign auto_go  = AUTO_RUN & auto_pend;

  assign pc_we      = commit;
  assign run_state  = state;
  assign halt_cause = cause;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_HALTED;
      halted    <= 1'b1;
      cause     <= HC_NONE;
      step_cnt  <= '0;
      auto_pend <= 1'b1;
    end else begin
      auto_pend <= 1'b0;
      unique case (state)
        ST_HALTED: begin
          if (!halt_req) begin
            if (step_req) begin
              state    <= ST_STEP;
              halted   <= 1'b0;
              step_cnt <= step_load(step_n);
            end else if (run_req || auto_go) begin
              state  <= ST_RUN;
              halted <= 1'b0;
            end
          end
        end
        ST_RUN, ST_STEP: begin
          if (halt_req) begin
            state    <= ST_HALTED;
            halted   <= 1'b1;
            cause    <= HC_HOST;
            step_cnt <= '0;
          end else if (bp_match) begin
            state    <= ST_HALTED;
            halted   <= 1'b1;
            cause    <= HC_BREAKPOINT;
            step_cnt <= '0;
          end else if (state == ST_STEP) begin
            step_cnt <= step_cnt - STEP_W'(1);
            if (step_cnt == STEP_W'(1)) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
              cause  <= HC_STEP_DONE;
            end
          end
        end
        default: begin
          state    <= ST_HALTED;
          halted   <= 1'b1;
          step_cnt <= '0;
        end
      endcase
    end
  end

  // Free-running count of retired instructions; wraps silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_cnt <= '0;
    end else if (commit) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scenario bench for cpu_run_ctrl: each task queues per-cycle stimulus with the
// expected outputs, then replays it and compares against the DUT cycle by cycle.
module tb_cpu_run_ctrl;

  localparam int CNT_W  = 4;
  localparam int STEP_W = 8;

  localparam logic [1:0] HLT = 2'b00, RUN = 2'b01, STP = 2'b10;
  localparam logic [1:0] C_NONE = 2'b00, C_HOST = 2'b01, C_DONE = 2'b10, C_BP = 2'b11;

  typedef struct packed {
    logic        rst;
    logic        r;
    logic        h;
    logic        s;
    logic [7:0]  n;
    logic [31:0] pc;
    logic        we;
    logic [1:0]  st;
    logic [1:0]  c;
  } stim_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run_req = 1'b0;
  logic              halt_req = 1'b0;
  logic              step_req = 1'b0;
  logic [STEP_W-1:0] step_n = '0;
  logic              bp_en = 1'b0;
  logic [31:0]       bp_addr = '0;
  logic [31:0]       pc_cur = '0;
  logic              pc_we;
  logic              halted;
  logic [1:0]        run_state;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  instr_cnt;

  cpu_run_ctrl #(.AUTO_RUN(1'b0), .CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .step_n     (step_n),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc_cur     (pc_cur),
    .pc_we      (pc_we),
    .halted     (halted),
    .run_state  (run_state),
    .halt_cause (halt_cause),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cnt_exp = 0;
  stim_t      q[$];
  logic [9:0] sb[$];
  logic [9:0] obs;
  logic [9:0] e;

  function automatic stim_t mk(input logic rs, input logic r, input logic h, input logic s,
                               input logic [7:0] n, input logic [31:0] pc, input logic we,
                               input logic [1:0] st, input logic [1:0] c);
    stim_t t;
    t.rst = rs; t.r = r; t.h = h; t.s = s; t.n = n; t.pc = pc;
    t.we = we; t.st = st; t.c = c;
    return t;
  endfunction

  task automatic apply(input stim_t t);
    rst_n    = t.rst;
    run_req  = t.r;
    halt_req = t.h;
    step_req = t.s;
    step_n   = t.n;
    pc_cur   = t.pc;
    sb.push_back({t.we, t.st == HLT, t.st, t.c, 4'(cnt_exp)});
  endtask

  task automatic finish_cycle(input stim_t t);
    @(posedge clk); #1;
    if (!t.rst) cnt_exp = 0;
    else if (t.we) cnt_exp++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    cnt_exp = 0;
    q.delete();
    q.push_back(mk(0, 1, 0, 1, 5, 0, 0, HLT, C_NONE));
    q.push_back(mk(0, 1, 0, 1, 5, 0, 0, HLT, C_NONE));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, HLT, C_NONE));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      obs = {pc_we, halted, run_state, halt_cause, instr_cnt};
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: dut we/hlt/st/cause/cnt=%b expected=%b", i, obs, e);
      end
      finish_cycle(q[i]);
    end
  endtask

  task automatic test_run_halt();
    q.delete();
    for (int i = 0; i < 16; i++)
      q.push_back(mk(1, i == 3, i == 14, 0, 0, 0, (i >= 4 && i <= 13),
                     (i >= 4 && i <= 14) ? RUN : HLT, (i == 15) ? C_HOST : C_NONE));
    q.push_back(mk(1, 0, 1, 1, 3, 0, 0, HLT, C_HOST));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, HLT, C_HOST));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      obs = {pc_we, halted, run_state, halt_cause, instr_cnt};
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL run_halt[%0d]: dut we/hlt/st/cause/cnt=%b expected=%b", i, obs, e);
      end
      finish_cycle(q[i]);
    end
  endtask

  task automatic test_step();
    logic [1:0] prev;
    logic [7:0] nv;
    prev = C_HOST;
    q.delete();
    for (int k = 0; k < 2; k++) begin
      nv = (k == 0) ? 8'd3 : 8'd0;
      q.push_back(mk(1, 0, 0, 1, nv, 0, 0, HLT, prev));
      for (int j = 0; j < ((nv == 0) ? 1 : int'(nv)); j++)
        q.push_back(mk(1, 0, 0, 0, 0, 0, 1, STP, prev));
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0, HLT, C_DONE));
      prev = C_DONE;
    end
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      obs = {pc_we, halted, run_state, halt_cause, instr_cnt};
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL step[%0d]: dut we/hlt/st/cause/cnt=%b expected=%b", i, obs, e);
      end
      finish_cycle(q[i]);
    end
  endtask

  task automatic test_breakpoint();
    logic [31:0] pc;
    logic        we;
    bp_en   = 1'b1;
    bp_addr = 32'h0000_0010;
    pc      = 32'h0;
    q.delete();
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, HLT, C_DONE));
    q.push_back(mk(1, 1, 0, 0, 0, pc, 0, HLT, C_NONE));
    for (int i = 0; i < 5; i++) begin
      we = (pc != 32'h10);
      q.push_back(mk(1, 0, 0, 0, 0, pc, we, RUN, C_NONE));
      if (we) pc += 4;
    end
    q.push_back(mk(1, 0, 0, 0, 0, 32'h10, 0, HLT, C_BP));
    q.push_back(mk(1, 1, 0, 0, 0, 32'h10, 0, HLT, C_BP));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h10, 1, RUN, C_BP));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h14, 1, RUN, C_BP));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h18, 1, RUN, C_BP));
    q.push_back(mk(1, 0, 1, 0, 0, 32'h1c, 0, RUN, C_BP));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h1c, 0, HLT, C_HOST));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      obs = {pc_we, halted, run_state, halt_cause, instr_cnt};
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL breakpoint[%0d]: dut we/hlt/st/cause/cnt=%b expected=%b", i, obs, e);
      end
      finish_cycle(q[i]);
    end
  endtask

  task automatic test_halt_bp();
    q.delete();
    q.push_back(mk(1, 1, 0, 0, 0, 32'h20, 0, HLT, C_HOST));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h20, 1, RUN, C_HOST));
    q.push_back(mk(1, 0, 1, 0, 0, 32'h10, 0, RUN, C_HOST));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h10, 0, HLT, C_HOST));
    q.push_back(mk(1, 1, 0, 0, 0, 32'h10, 0, HLT, C_HOST));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h10, 0, RUN, C_HOST));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h10, 0, HLT, C_BP));
    q.push_back(mk(1, 0, 0, 1, 2, 32'h10, 0, HLT, C_BP));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h10, 1, STP, C_BP));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h10, 0, STP, C_BP));
    q.push_back(mk(1, 0, 0, 0, 0, 32'h10, 0, HLT, C_BP));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      obs = {pc_we, halted, run_state, halt_cause, instr_cnt};
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL halt_bp[%0d]: dut we/hlt/st/cause/cnt=%b expected=%b", i, obs, e);
      end
      finish_cycle(q[i]);
    end
  endtask

  task automatic test_wrap_reset();
    bp_en = 1'b0;
    q.delete();
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, HLT, C_BP));
    q.push_back(mk(1, 1, 0, 0, 0, 0, 0, HLT, C_NONE));
    for (int i = 0; i < 17; i++)
      q.push_back(mk(1, 0, 0, 0, 0, 0, 1, RUN, C_NONE));
    q.push_back(mk(1, 0, 1, 0, 0, 0, 0, RUN, C_NONE));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, HLT, C_HOST));
    q.push_back(mk(1, 0, 0, 1, 5, 0, 0, HLT, C_HOST));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, STP, C_HOST));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, STP, C_HOST));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, STP, C_HOST));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, HLT, C_NONE));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, HLT, C_NONE));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk);
      obs = {pc_we, halted, run_state, halt_cause, instr_cnt};
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL wrap_reset[%0d]: dut we/hlt/st/cause/cnt=%b expected=%b", i, obs, e);
      end
      finish_cycle(q[i]);
    end
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_step();
    test_breakpoint();
    test_halt_bp();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
